axis_uart_tx_sched: RTL and testbench

Transmit-side scheduler for the AXI-Stream UART TX core. Shares one `axis_uart_tx` instance among NUM_SRC AXI-Stream requesters with round-robin, packet-locked arbitration, and generates the `uart_ena` baud strobe that paces the core. It sits between the requester streams and `axis_uart_tx`: `m_axis_*` drives the core's `s_axis_*`, and `uart_ena` drives the core's `uart_ena`.

---
 rtl/axis_uart_pkg.sv | 19 +
 rtl/axis_uart_tx_sched_if.sv | 13 +
 rtl/uart_baud_gen.sv | 35 +++
 rtl/axis_uart_tx_sched.sv | 133 +++++++++++++
 tb/tb_axis_uart_tx_sched.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_uart_pkg.sv
// Shared state encoding and elaboration helpers for the AXI-Stream UART TX scheduler.
package axis_uart_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } sched_state_e;

    // Ceiling log2; returns 0 for inputs of 0 or 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_uart_tx_sched_if.sv
// AXI-Stream bundle carrying N_LANES independent streams side by side.
interface axis_uart_tx_sched_if #(
    parameter int unsigned N_LANES   = 1,
    parameter int unsigned DATA_BITS = 8
);
    logic [N_LANES*DATA_BITS-1:0] tdata;
    logic [N_LANES-1:0]           tvalid;
    logic [N_LANES-1:0]           tlast;
    logic [N_LANES-1:0]           tready;

    modport master (output tdata, tvalid, tlast, input tready);
    modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/uart_baud_gen.sv
// Free-running baud divider: one-cycle uart_ena every baud_div+1 clock cycles.
module uart_baud_gen #(
    parameter int unsigned BAUD_DIV_WIDTH = 16
) (
    input  logic                      aclk,
    input  logic                      arstn,
    input  logic [BAUD_DIV_WIDTH-1:0] baud_div,
    output logic                      uart_ena
);
    logic [BAUD_DIV_WIDTH-1:0] baud_cnt_q, baud_cnt_d;
    logic                      uart_ena_q, uart_ena_d;

    // >= rather than == so a shrinking divider wraps at once instead of running to the top.
    always_comb begin
        baud_cnt_d = baud_cnt_q + BAUD_DIV_WIDTH'(1);
        uart_ena_d = 1'b0;
        if (baud_cnt_q >= baud_div) begin
            baud_cnt_d = '0;
            uart_ena_d = 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (!arstn) begin
            baud_cnt_q <= '0;
            uart_ena_q <= 1'b0;
        end else begin
            baud_cnt_q <= baud_cnt_d;
            uart_ena_q <= uart_ena_d;
        end
    end

    assign uart_ena = uart_ena_q;

endmodule

// File: rtl/axis_uart_tx_sched.sv
// Round-robin, packet-locked arbiter sharing one UART TX core among NUM_SRC AXI-Stream
// requesters, plus the baud strobe that paces the core.
module axis_uart_tx_sched
    import axis_uart_pkg::*;
#(
    parameter int unsigned NUM_SRC        = 4,
    parameter int unsigned DATA_BITS      = 8,
    parameter int unsigned MAX_BURST      = 16,
    parameter int unsigned BAUD_DIV_WIDTH = 16
) (
    input  logic                      aclk,
    input  logic                      arstn,
    input  logic [BAUD_DIV_WIDTH-1:0] baud_div,
    axis_uart_tx_sched_if.slave       s_axis,
    axis_uart_tx_sched_if.master      m_axis,
    output logic                      uart_ena,
    output logic [NUM_SRC-1:0]        grant,
    output logic                      busy
);
    localparam int unsigned IDX_W = (clog2(NUM_SRC) > 0) ? clog2(NUM_SRC) : 1;
    localparam int unsigned CNT_W = (clog2(MAX_BURST) > 0) ? clog2(MAX_BURST) : 1;

    sched_state_e       state_q, state_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   cand;
    logic [DATA_BITS-1:0] m_tdata_c;
    logic               m_tvalid_c;
    logic               m_tlast_c;
    logic [NUM_SRC-1:0] s_tready_c;
    logic               beat_acc;

    // First valid requester at or after rr_ptr, searching upward with wrap.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            cand = IDX_W'((32'(rr_ptr_q) + k) % NUM_SRC);
            if (!pick_found && s_axis.tvalid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Zero-latency pass-through from the owner; gated by reset so nothing is accepted then.
    always_comb begin
        m_tdata_c  = '0;
        m_tvalid_c = 1'b0;
        m_tlast_c  = 1'b0;
        s_tready_c = '0;
        if (state_q == XFER && arstn) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (gidx_q == IDX_W'(i)) m_tdata_c = s_axis.tdata[i*DATA_BITS +: DATA_BITS];
            end
            m_tvalid_c         = s_axis.tvalid[gidx_q];
            m_tlast_c          = s_axis.tlast[gidx_q];
            s_tready_c[gidx_q] = m_axis.tready[0];
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        beat_acc   = m_tvalid_c && m_axis.tready[0];
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d           = XFER;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    gidx_d            = pick_idx;
                    beat_cnt_d        = '0;
                end
            end
            XFER: begin
                if (beat_acc) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    // tlast and the burst cap on the same beat end the burst once.
                    if (m_tlast_c || beat_cnt_q == CNT_W'(MAX_BURST - 1)) begin
                        state_d    = IDLE;
                        grant_d    = '0;
                        beat_cnt_d = '0;
                        rr_ptr_d   = (gidx_q == IDX_W'(NUM_SRC - 1)) ? '0 : gidx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!arstn) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    uart_baud_gen #(
        .BAUD_DIV_WIDTH(BAUD_DIV_WIDTH)
    ) u_baud_gen (
        .aclk    (aclk),
        .arstn   (arstn),
        .baud_div(baud_div),
        .uart_ena(uart_ena)
    );

    assign m_axis.tdata  = m_tdata_c;
    assign m_axis.tvalid = m_tvalid_c;
    assign m_axis.tlast  = m_tlast_c;
    assign s_axis.tready = s_tready_c;
    assign grant         = grant_q;
    assign busy          = (state_q == XFER);

endmodule

// File: tb/tb_axis_uart_tx_sched.sv
// Directed bench for axis_uart_tx_sched: vector table for arbitration, hand sequences
// for backpressure and the baud generator.
module tb_axis_uart_tx_sched;
    localparam int unsigned NUM_SRC   = 4;
    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned MAX_BURST = 4;
    localparam int unsigned BDW       = 16;

    logic           aclk = 1'b0;
    logic           arstn;
    logic [BDW-1:0] baud_div;
    logic           uart_ena;
    logic [3:0]     grant;
    logic           busy;

    int n_checks = 0;
    int n_fail   = 0;

    axis_uart_tx_sched_if #(.N_LANES(NUM_SRC), .DATA_BITS(DATA_BITS)) s_if ();
    axis_uart_tx_sched_if #(.N_LANES(1),       .DATA_BITS(DATA_BITS)) m_if ();

    always #5 aclk = ~aclk;

    axis_uart_tx_sched #(
        .NUM_SRC       (NUM_SRC),
        .DATA_BITS     (DATA_BITS),
        .MAX_BURST     (MAX_BURST),
        .BAUD_DIV_WIDTH(BDW)
    ) dut (
        .aclk    (aclk),
        .arstn   (arstn),
        .baud_div(baud_div),
        .s_axis  (s_if),
        .m_axis  (m_if),
        .uart_ena(uart_ena),
        .grant   (grant),
        .busy    (busy)
    );

    typedef struct {
        logic        rstn;
        logic [3:0]  vld;
        logic [3:0]  lst;
        logic [31:0] dat;
        logic [3:0]  e_grant;
        logic        e_busy;
        logic        e_mvalid;
        logic [7:0]  e_mdata;
        logic [3:0]  e_tready;
    } vec_t;

    vec_t tbl[$];
    logic [7:0] got[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rstn, input logic [3:0] vld, input logic [3:0] lst,
                       input logic [31:0] dat, input logic [3:0] eg, input logic eb,
                       input logic emv, input logic [7:0] emd, input logic [3:0] etr);
        vec_t v;
        v.rstn = rstn; v.vld = vld; v.lst = lst; v.dat = dat;
        v.e_grant = eg; v.e_busy = eb; v.e_mvalid = emv; v.e_mdata = emd; v.e_tready = etr;
        tbl.push_back(v);
    endtask

    task automatic idle_row(input logic rstn, input logic [3:0] vld, input logic [3:0] lst,
                            input logic [31:0] dat);
        add(rstn, vld, lst, dat, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000);
    endtask

    task automatic do_reset(input logic [BDW-1:0] div);
        @(negedge aclk);
        arstn       = 1'b0;
        baud_div    = div;
        s_if.tvalid = '0;
        @(posedge aclk);
        @(negedge aclk);
        arstn = 1'b1;
    endtask

    // Counts falling edges until uart_ena is seen high.
    task automatic wait_pulse(input string name, input int expect_n);
        int n;
        n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while (uart_ena !== 1'b1 && n < 400);
        check(name, 32'(n), 32'(expect_n));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        logic mrdy;

        arstn       = 1'b0;
        baud_div    = 16'hFFFF;
        s_if.tvalid = 4'b1111;
        s_if.tlast  = 4'b0000;
        s_if.tdata  = 32'h44332211;
        m_if.tready = 1'b1;
        @(posedge aclk);

        // Reset hold with every source requesting.
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk); #1;
            check("rst grant",  32'(grant),       32'h0);
            check("rst tready", 32'(s_if.tready), 32'h0);
            check("rst ena",    32'(uart_ena),    32'h0);
            check("rst mvalid", 32'(m_if.tvalid), 32'h0);
            check("rst busy",   32'(busy),        32'h0);
        end

        // Single source 2: three beats, tlast on the third.
        idle_row(1'b1, 4'b0000, 4'b0000, 32'h0);
        idle_row(1'b1, 4'b0100, 4'b0000, 32'h00410000);
        add(1'b1, 4'b0100, 4'b0000, 32'h00410000, 4'b0100, 1, 1, 8'h41, 4'b0100);
        add(1'b1, 4'b0100, 4'b0000, 32'h00420000, 4'b0100, 1, 1, 8'h42, 4'b0100);
        add(1'b1, 4'b0100, 4'b0100, 32'h00430000, 4'b0100, 1, 1, 8'h43, 4'b0100);
        idle_row(1'b1, 4'b0000, 4'b0000, 32'h0);
        // Reset clears rr_ptr, then round robin with 1-beat packets.
        idle_row(1'b0, 4'b0000, 4'b0000, 32'h0);
        idle_row(1'b1, 4'b1111, 4'b1111, 32'h13121110);
        add(1'b1, 4'b1111, 4'b1111, 32'h13121110, 4'b0001, 1, 1, 8'h10, 4'b0001);
        idle_row(1'b1, 4'b1111, 4'b1111, 32'h13121110);
        add(1'b1, 4'b1111, 4'b1111, 32'h13121110, 4'b0010, 1, 1, 8'h11, 4'b0010);
        idle_row(1'b1, 4'b1111, 4'b1111, 32'h13121110);
        add(1'b1, 4'b1111, 4'b1111, 32'h13121110, 4'b0100, 1, 1, 8'h12, 4'b0100);
        idle_row(1'b1, 4'b1111, 4'b1111, 32'h13121110);
        add(1'b1, 4'b1111, 4'b1111, 32'h13121110, 4'b1000, 1, 1, 8'h13, 4'b1000);
        idle_row(1'b1, 4'b1111, 4'b1111, 32'h13121110);
        add(1'b1, 4'b1111, 4'b1111, 32'h13121110, 4'b0001, 1, 1, 8'h10, 4'b0001);
        idle_row(1'b1, 4'b0000, 4'b0000, 32'h0);
        // Burst cap of 4: source 1 streams, source 3 waits its turn.
        idle_row(1'b1, 4'b1010, 4'b1000, 32'h33002000);
        add(1'b1, 4'b1010, 4'b1000, 32'h33002000, 4'b0010, 1, 1, 8'h20, 4'b0010);
        add(1'b1, 4'b1010, 4'b1000, 32'h33002100, 4'b0010, 1, 1, 8'h21, 4'b0010);
        add(1'b1, 4'b1010, 4'b1000, 32'h33002200, 4'b0010, 1, 1, 8'h22, 4'b0010);
        add(1'b1, 4'b1010, 4'b1000, 32'h33002300, 4'b0010, 1, 1, 8'h23, 4'b0010);
        idle_row(1'b1, 4'b1010, 4'b1000, 32'h33002400);
        add(1'b1, 4'b1010, 4'b1000, 32'h33002400, 4'b1000, 1, 1, 8'h33, 4'b1000);
        idle_row(1'b1, 4'b0010, 4'b0000, 32'h00002400);
        add(1'b1, 4'b0010, 4'b0000, 32'h00002400, 4'b0010, 1, 1, 8'h24, 4'b0010);
        add(1'b1, 4'b0010, 4'b0000, 32'h00002500, 4'b0010, 1, 1, 8'h25, 4'b0010);
        add(1'b1, 4'b0010, 4'b0000, 32'h00002600, 4'b0010, 1, 1, 8'h26, 4'b0010);
        add(1'b1, 4'b0010, 4'b0000, 32'h00002700, 4'b0010, 1, 1, 8'h27, 4'b0010);
        idle_row(1'b1, 4'b0010, 4'b0000, 32'h00002800);
        add(1'b1, 4'b0010, 4'b0000, 32'h00002800, 4'b0010, 1, 1, 8'h28, 4'b0010);
        add(1'b1, 4'b0010, 4'b0000, 32'h00002900, 4'b0010, 1, 1, 8'h29, 4'b0010);
        // Owner drops tvalid mid-burst: grant held, nothing presented.
        add(1'b1, 4'b0000, 4'b0000, 32'h0,        4'b0010, 1, 0, 8'h00, 4'b0010);
        add(1'b1, 4'b0000, 4'b0000, 32'h0,        4'b0010, 1, 0, 8'h00, 4'b0010);
        add(1'b1, 4'b0010, 4'b0010, 32'h00002A00, 4'b0010, 1, 1, 8'h2A, 4'b0010);
        idle_row(1'b1, 4'b0000, 4'b0000, 32'h0);

        foreach (tbl[i]) begin
            @(negedge aclk);
            arstn       = tbl[i].rstn;
            s_if.tvalid = tbl[i].vld;
            s_if.tlast  = tbl[i].lst;
            s_if.tdata  = tbl[i].dat;
            m_if.tready = 1'b1;
            #1;
            check($sformatf("row%0d grant", i),  32'(grant),       32'(tbl[i].e_grant));
            check($sformatf("row%0d busy", i),   32'(busy),        32'(tbl[i].e_busy));
            check($sformatf("row%0d mvalid", i), 32'(m_if.tvalid), 32'(tbl[i].e_mvalid));
            check($sformatf("row%0d tready", i), 32'(s_if.tready), 32'(tbl[i].e_tready));
            if (tbl[i].e_mvalid)
                check($sformatf("row%0d mdata", i), 32'(m_if.tdata), 32'(tbl[i].e_mdata));
        end

        // Backpressure: m_axis_tready toggles, source 0 sends 0x50..0x52.
        @(negedge aclk);
        s_if.tvalid = 4'b0001;
        s_if.tlast  = 4'b0000;
        s_if.tdata  = 32'h00000050;
        m_if.tready = 1'b0;
        #1;
        check("bp pre grant", 32'(grant), 32'h0);
        idx = 0;
        for (int cyc = 0; cyc < 30 && idx < 3; cyc++) begin
            @(negedge aclk);
            mrdy             = (cyc % 2) == 1;
            m_if.tready      = mrdy;
            s_if.tdata[7:0]  = 8'h50 + 8'(idx);
            s_if.tlast[0]    = (idx == 2);
            #1;
            check("bp grant",  32'(grant),       32'h1);
            check("bp mvalid", 32'(m_if.tvalid), 32'h1);
            check("bp mdata",  32'(m_if.tdata),  32'h50 + 32'(idx));
            check("bp tlast",  32'(m_if.tlast),  32'(idx == 2));
            check("bp tready", 32'(s_if.tready), 32'(mrdy));
            if (m_if.tvalid && m_if.tready[0]) got.push_back(m_if.tdata);
            if (mrdy) idx++;
        end
        check("bp beats", 32'(idx), 32'd3);
        @(negedge aclk);
        s_if.tvalid = 4'b0000;
        #1;
        check("bp end grant", 32'(grant), 32'h0);
        check("bp end busy",  32'(busy),  32'h0);
        check("bp got count", 32'(got.size()), 32'd3);
        for (int k = 0; k < got.size() && k < 3; k++)
            check($sformatf("bp got%0d", k), 32'(got[k]), 32'h50 + 32'(k));

        // Baud generator: divider 99, then 0, then a mid-count decrease.
        do_reset(16'd99);
        wait_pulse("baud first", 100);
        wait_pulse("baud period", 100);
        wait_pulse("baud period2", 100);
        baud_div = 16'd0;
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            check($sformatf("baud div0 %0d", i), 32'(uart_ena), 32'h1);
        end
        do_reset(16'd99);
        repeat (50) @(posedge aclk);
        @(negedge aclk);
        check("baud pre-change", 32'(uart_ena), 32'h0);
        baud_div = 16'd10;
        @(negedge aclk);
        check("baud wrap", 32'(uart_ena), 32'h1);
        wait_pulse("baud div10 period", 11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
